// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD-card DAT0 block write path.
// State enum, CRC16-CCITT polynomial, data-response token codes and a serial CRC step helper.
package sdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_BIT = 3'd1,
        ST_DATA      = 3'd2,
        ST_CRC       = 3'd3,
        ST_END_BIT   = 3'd4,
        ST_RESP      = 3'd5,
        ST_WAIT_BUSY = 3'd6,
        ST_DONE      = 3'd7
    } state_e;

    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [2:0]  RESP_ACCEPTED = 3'b010;
    localparam logic [2:0]  RESP_CRC_ERR  = 3'b101;
    localparam logic [2:0]  RESP_WR_ERR   = 3'b110;
    localparam logic        START_BIT     = 1'b0;
    localparam logic        END_BIT       = 1'b1;

    // One bit of x^16+x^12+x^5+1 in the usual feedback (MSB-out) form.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sdc_crc16.sv
// Serial CRC16-CCITT accumulator (init 0) fed one data bit per enabled clock.
module sdc_crc16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);
    import sdc_pkg::*;

    // CRC register: cleared at block start, advanced once per data bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 16'h0000;
        end else if (clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/sdc_block_serializer.sv
// Drives one SD write block on DAT0: start bit, data bytes MSB-first, CRC16, end bit.
// Optional macro RESP_CHECK_EN adds capture of the card's data-response token and busy wait.
module sdc_block_serializer #(
    parameter int BLOCK_BYTES = 512,
    parameter int CRC_W       = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       sd_dat_out,
    output logic       sd_dat_oe,
    input  logic       sd_dat_in,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic       resp_err
);
    import sdc_pkg::*;

    localparam int            BW        = $clog2(BLOCK_BYTES);
    localparam int            CW        = $clog2(CRC_W);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_BYTES - 1);
    localparam logic [BW-1:0] BYTE_ONE  = BW'(1);
    localparam logic [CW-1:0] LAST_CRC  = CW'(CRC_W - 1);
    localparam logic [CW-1:0] CRC_ONE   = CW'(1);

    state_e        state_r, state_nxt_s;
    logic [BW-1:0] byte_cnt_r, byte_cnt_nxt_s;
    logic [2:0]    bit_cnt_r, bit_cnt_nxt_s;
    logic [CW-1:0] crc_idx_r, crc_idx_nxt_s;
    logic [7:0]    shift_r, shift_nxt_s;
    logic          underrun_nxt_s;
    logic          dat_nxt_s, oe_nxt_s, ready_nxt_s, busy_nxt_s, done_nxt_s;
    logic          crc_clr_s, crc_en_s, crc_din_s;
    logic [15:0]   crc_s;
`ifdef RESP_CHECK_EN
    logic [2:0]    resp_cnt_r, resp_cnt_nxt_s;
    logic [2:0]    resp_sr_r, resp_sr_nxt_s;
    logic          got_tok_r, got_tok_nxt_s;
    logic          resp_err_nxt_s;
`endif

    sdc_crc16 u_crc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (crc_clr_s),
        .en      (crc_en_s),
        .din     (crc_din_s),
        .crc     (crc_s)
    );

    // Next-state/datapath, then decode of the values the output flops take next cycle
    always_comb begin
        state_nxt_s    = state_r;
        byte_cnt_nxt_s = byte_cnt_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        crc_idx_nxt_s  = crc_idx_r;
        shift_nxt_s    = shift_r;
        underrun_nxt_s = underrun;
        crc_clr_s      = 1'b0;
`ifdef RESP_CHECK_EN
        resp_cnt_nxt_s = resp_cnt_r;
        resp_sr_nxt_s  = resp_sr_r;
        got_tok_nxt_s  = got_tok_r;
        resp_err_nxt_s = resp_err;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s    = ST_START_BIT;
                    byte_cnt_nxt_s = {BW{1'b0}};
                    bit_cnt_nxt_s  = 3'd0;
                    underrun_nxt_s = 1'b0;
                    crc_clr_s      = 1'b1;
`ifdef RESP_CHECK_EN
                    resp_err_nxt_s = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START_BIT: begin
                if (byte_valid) begin
                    state_nxt_s = ST_DATA;
                    shift_nxt_s = byte_data;
                end else begin
                    underrun_nxt_s = 1'b1;
                    state_nxt_s    = ST_DONE;
                end
            end
            ST_DATA: begin
                if (bit_cnt_r != 3'd7) begin
                    shift_nxt_s   = {shift_r[6:0], 1'b0};
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                end else if (byte_cnt_r == LAST_BYTE) begin
                    state_nxt_s   = ST_CRC;
                    crc_idx_nxt_s = {CW{1'b0}};
                end else if (byte_valid) begin
                    shift_nxt_s    = byte_data;
                    bit_cnt_nxt_s  = 3'd0;
                    byte_cnt_nxt_s = byte_cnt_r + BYTE_ONE;
                end else begin
                    underrun_nxt_s = 1'b1;
                    state_nxt_s    = ST_DONE;
                end
            end
            ST_CRC: begin
                if (crc_idx_r == LAST_CRC) begin
                    state_nxt_s = ST_END_BIT;
                end else begin
                    crc_idx_nxt_s = crc_idx_r + CRC_ONE;
                end
            end
            ST_END_BIT: begin
`ifdef RESP_CHECK_EN
                state_nxt_s    = ST_RESP;
                resp_cnt_nxt_s = 3'd0;
                got_tok_nxt_s  = 1'b0;
`else
                state_nxt_s    = ST_DONE;
`endif
            end
`ifdef RESP_CHECK_EN
            ST_RESP: begin
                // Token: start bit within 8 cycles, 3 status bits, end bit
                if (!got_tok_r) begin
                    if (sd_dat_in == START_BIT) begin
                        got_tok_nxt_s  = 1'b1;
                        resp_cnt_nxt_s = 3'd0;
                    end else if (resp_cnt_r == 3'd7) begin
                        resp_err_nxt_s = 1'b1;
                        state_nxt_s    = ST_DONE;
                    end else begin
                        resp_cnt_nxt_s = resp_cnt_r + 3'd1;
                    end
                end else if (resp_cnt_r == 3'd3) begin
                    if ((resp_sr_r != RESP_ACCEPTED) || (sd_dat_in != END_BIT)) begin
                        resp_err_nxt_s = 1'b1;
                    end else begin
                        resp_err_nxt_s = resp_err;
                    end
                    state_nxt_s = ST_WAIT_BUSY;
                end else begin
                    resp_sr_nxt_s  = {resp_sr_r[1:0], sd_dat_in};
                    resp_cnt_nxt_s = resp_cnt_r + 3'd1;
                end
            end
            ST_WAIT_BUSY: begin
                if (sd_dat_in == 1'b1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT_BUSY;
                end
            end
`endif
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // The CRC sees each data bit as it is loaded into the output flop
        crc_en_s  = (state_nxt_s == ST_DATA);
        crc_din_s = shift_nxt_s[7];

        case (state_nxt_s)
            ST_START_BIT: dat_nxt_s = START_BIT;
            ST_DATA:      dat_nxt_s = shift_nxt_s[7];
            ST_CRC:       dat_nxt_s = crc_s[LAST_CRC - crc_idx_nxt_s];
            default:      dat_nxt_s = END_BIT;
        endcase
        oe_nxt_s    = (state_nxt_s == ST_START_BIT) || (state_nxt_s == ST_DATA) ||
                      (state_nxt_s == ST_CRC) || (state_nxt_s == ST_END_BIT);
        ready_nxt_s = (state_nxt_s == ST_START_BIT) ||
                      ((state_nxt_s == ST_DATA) && (bit_cnt_nxt_s == 3'd7) &&
                       (byte_cnt_nxt_s != LAST_BYTE));
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        done_nxt_s  = (state_nxt_s == ST_DONE);
    end

    // State, counters, shift register and output flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= {BW{1'b0}};
            bit_cnt_r  <= 3'd0;
            crc_idx_r  <= {CW{1'b0}};
            shift_r    <= 8'h00;
            sd_dat_out <= 1'b1;
            sd_dat_oe  <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            crc_idx_r  <= crc_idx_nxt_s;
            shift_r    <= shift_nxt_s;
            sd_dat_out <= dat_nxt_s;
            sd_dat_oe  <= oe_nxt_s;
            byte_ready <= ready_nxt_s;
            busy       <= busy_nxt_s;
            done       <= done_nxt_s;
            underrun   <= underrun_nxt_s;
        end
    end

`ifdef RESP_CHECK_EN
    // Response-token capture and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_cnt_r <= 3'd0;
            resp_sr_r  <= 3'd0;
            got_tok_r  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            resp_cnt_r <= resp_cnt_nxt_s;
            resp_sr_r  <= resp_sr_nxt_s;
            got_tok_r  <= got_tok_nxt_s;
            resp_err   <= resp_err_nxt_s;
        end
    end
`else
    logic unused_s;
    assign unused_s = sd_dat_in;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdc_block_serializer.sv
// Self-checking bench for sdc_block_serializer: table of block scenarios plus reset/response sequences.
// Reference: expected DAT0 stream and CRC (polynomial long division) derived from the block contents.
module tb_sdc_block_serializer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       sd_dat_in = 1'b1;
    logic       byte_ready, sd_dat_out, sd_dat_oe, busy, done, underrun, resp_err;

    int total = 0;
    int bad   = 0;
    logic [7:0] blk [512];

`ifdef RESP_CHECK_EN
    localparam int RESP_OFS = 8;
    localparam bit RESP_ON  = 1'b1;
`else
    localparam int RESP_OFS = 0;
    localparam bit RESP_ON  = 1'b0;
`endif

    typedef struct {
        int pat;        // 0: all FF, 1: ramp, 2: random
        int drop;       // byte index whose valid never comes, -1 none
        int restart;    // cycle with a stray start pulse, -1 none
        int exp_done;   // cycle of done pulse (start accepted at cycle 0)
        int exp_ready;  // byte_ready high cycles
        bit exp_unr;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    sdc_block_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .sd_dat_out (sd_dat_out),
        .sd_dat_oe  (sd_dat_oe),
        .sd_dat_in  (sd_dat_in),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun),
        .resp_err   (resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 512; i++) begin
            case (pat)
                0:       blk[i] = 8'hFF;
                1:       blk[i] = i[7:0];
                default: blk[i] = 8'($urandom);
            endcase
        end
    endtask

    // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] ref_crc();
        bit          m [4112];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h11021;
        for (int i = 0; i < 4112; i++) m[i] = (i < 4096) ? blk[i / 8][7 - (i % 8)] : 1'b0;
        for (int i = 0; i < 4096; i++)
            if (m[i]) for (int k = 0; k < 17; k++) m[i + k] ^= g[16 - k];
        for (int j = 0; j < 16; j++) r[15 - j] = m[4096 + j];
        return r;
    endfunction

    function automatic logic exp_bit(input int cyc, input logic [15:0] crc);
        if (cyc == 1) return 1'b0;
        else if (cyc <= 4097) return blk[(cyc - 2) / 8][7 - ((cyc - 2) % 8)];
        else if (cyc <= 4113) return crc[15 - (cyc - 4098)];
        else return 1'b1;
    endfunction

    // Card model: token starts two cycles after the line is released (cycle 4115)
    function automatic logic card_bit(input int card, input int cyc);
        int         t;
        logic [2:0] status;
        int         busy_len;
        t        = cyc - 4117;
        status   = (card == 1) ? 3'b010 : 3'b101;
        busy_len = (card == 1) ? 20 : 2;
        if (card == 0 || t < 0) return 1'b1;
        if (t == 0) return 1'b0;
        if (t <= 3) return status[3 - t];
        if (t == 4) return 1'b1;
        if (t < 5 + busy_len) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_block(input int drop, input int restart, input int card, input int exp_done,
                             input int exp_ready, input bit exp_unr, input bit exp_rerr, input bit fixed_crc);
        logic [15:0] mcrc, got_crc;
        int  idx, last_drv, done_cyc, done_cnt, serr, rdy_cnt, post_bad, unr_at, rerr_at;
        bit  acc;
        mcrc = ref_crc();
        got_crc = 16'h0000;
        idx = 0; done_cyc = -1; done_cnt = 0; serr = 0; rdy_cnt = 0; post_bad = 0;
        unr_at = -1; rerr_at = -1; acc = 1'b0;
        last_drv = (drop >= 0) ? 8 * drop + 1 : 4114;
        @(negedge clk);
        start = 1'b1;
        byte_data = blk[0];
        byte_valid = (drop != 0);
        for (int cyc = 1; cyc <= 4300; cyc++) begin
            @(negedge clk);
            start = (cyc == restart);
            if (acc) begin
                idx++;
                acc = 1'b0;
                byte_data = blk[idx % 512];
                byte_valid = (idx != drop);
            end
            sd_dat_in = card_bit(card, cyc);
            if (byte_ready) rdy_cnt++;
            if (byte_ready && byte_valid) acc = 1'b1;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    unr_at = int'(underrun);
                    rerr_at = int'(resp_err);
                end
            end
            if (done_cyc < 0) begin
                if (busy !== 1'b1) serr++;
                if (cyc <= last_drv) begin
                    if (sd_dat_oe !== 1'b1 || sd_dat_out !== exp_bit(cyc, mcrc)) serr++;
                end else if (sd_dat_oe !== 1'b0 || sd_dat_out !== 1'b1) begin
                    serr++;
                end
                if (cyc >= 4098 && cyc <= 4113) got_crc[4113 - cyc] = sd_dat_out;
            end else if (cyc == done_cyc) begin
                if (sd_dat_oe !== 1'b0 || sd_dat_out !== 1'b1 || busy !== 1'b1) serr++;
            end else if (busy !== 1'b0 || sd_dat_oe !== 1'b0) begin
                post_bad++;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        sd_dat_in = 1'b1;
        check("done_cycle", done_cyc, exp_done);
        check("done_count", done_cnt, 1);
        check("stream_errors", serr, 0);
        check("ready_pulses", rdy_cnt, exp_ready);
        check("underrun", unr_at, int'(exp_unr));
        check("resp_err", rerr_at, int'(exp_rerr));
        check("after_done", post_bad, 0);
        if (drop < 0) check("crc", got_crc, mcrc);
        if (fixed_crc) check("crc_all_ff", got_crc, 16'h7FA1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int d;
        vecs[0] = '{0, -1,   -1, 4115, 512, 1'b0};
        vecs[1] = '{1, -1,   -1, 4115, 512, 1'b0};
        vecs[2] = '{2, 100,  -1,  802, 101, 1'b1};
        vecs[3] = '{1, -1,  1000, 4115, 512, 1'b0};
        vecs[4] = '{2,  0,   -1,    2,   1, 1'b1};
        vecs[5] = '{2, -1,  4114, 4115, 512, 1'b0};
        vecs[6] = '{2, 511,  -1, 4090, 512, 1'b1};
        vecs[7] = '{1, -1,   -1, 4115, 512, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_dat", sd_dat_out, 1);
        check("rst_oe", sd_dat_oe, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_resp_err", resp_err, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset at data bit 2000
        start = 1'b1;
        byte_valid = 1'b1;
        byte_data = 8'hA5;
        for (int c = 1; c <= 2002; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_oe", sd_dat_oe, 1);
        check("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("arst_oe", sd_dat_oe, 0);
        check("arst_dat", sd_dat_out, 1);
        check("arst_busy", busy, 0);
        check("arst_ready", byte_ready, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].pat);
            run_block(vecs[v].drop, vecs[v].restart, 0,
                      vecs[v].exp_done + ((vecs[v].drop < 0) ? RESP_OFS : 0),
                      vecs[v].exp_ready, vecs[v].exp_unr,
                      (vecs[v].drop < 0) && RESP_ON, vecs[v].pat == 0);
        end

        // Random contents with an underrun at a random byte
        d = int'($urandom_range(510, 1));
        fill(2);
        run_block(d, -1, 0, 8 * d + 2, d + 1, 1'b1, 1'b0, 1'b0);

`ifdef RESP_CHECK_EN
        fill(1);
        run_block(-1, -1, 1, 4143, 512, 1'b0, 1'b0, 1'b0);
        fill(2);
        run_block(-1, -1, 2, 4125, 512, 1'b0, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
